// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// wb_rr_arbiter : round-robin Wishbone arbiter, cycle-exclusive grant, watchdog
// Revision      : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_INIT  = IW'(NUM_MASTERS - 1);
    localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);
    localparam logic [WW-1:0] WDOG_MAX   = {WW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [IW-1:0]          last, last_nxt;
    logic [WW-1:0]          wdog, wdog_nxt;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          winner;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   term;
    logic                   busy;
    logic                   abort;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_INIT;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // Owner index; defaults to master 0 when idle so the mux has a defined source.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) owner = IW'(i);
        end
    end

    // Scan from farthest to nearest so the requester closest after last wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (wbm_cyc_i[(int'(last) + k) % NUM_MASTERS]) begin
                winner = IW'((int'(last) + k) % NUM_MASTERS);
            end
        end
    end

    assign own_cyc = wbm_cyc_i[owner];
    assign own_stb = wbm_stb_i[owner];
    assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign busy    = (state == BUSY);
    assign abort   = (state == ABORT);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        wdog_nxt  = '0;
        case (state)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    state_nxt = BUSY;
                    grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = owner;
                end else if (own_stb && !term) begin
                    wdog_nxt = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
                    if (TIMEOUT != 0 && wdog == WDOG_LIMIT) state_nxt = ABORT;
                end
            end
            ABORT: begin
                if (own_cyc) begin
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = owner;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign wbs_adr_o = wbm_adr_i[int'(owner)*AW +: AW];
    assign wbs_dat_o = wbm_dat_i[int'(owner)*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[int'(owner)*SW +: SW];
    assign wbs_cti_o = wbm_cti_i[int'(owner)*3 +: 3];
    assign wbs_bte_o = wbm_bte_i[int'(owner)*2 +: 2];
    assign wbs_we_o  = busy & wbm_we_i[owner];
    assign wbs_cyc_o = busy & own_cyc;
    assign wbs_stb_o = busy & own_stb;

    // Slave responses during ABORT are deliberately dropped.
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign wbm_ack_o = grant & {NUM_MASTERS{busy & wbs_ack_i}};
    assign wbm_err_o = grant & {NUM_MASTERS{(busy & wbs_err_i) | abort}};
    assign wbm_rty_o = grant & {NUM_MASTERS{busy & wbs_rty_i}};
    assign grant_o   = grant;
    assign timeout_o = abort;

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
// tb_wb_rr_arbiter : directed and random checks of two arbiters (TIMEOUT 8 / 0)
// Revision         : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N*AW-1:0]  m_adr;
    logic [N*DW-1:0]  m_dat;
    logic [N*SW-1:0]  m_sel;
    logic [N-1:0]     m_we, m_cyc, m_stb;
    logic [N*3-1:0]   m_cti;
    logic [N*2-1:0]   m_bte;
    logic [DW-1:0]    s_dat;
    logic             s_ack, s_err, s_rty;

    logic [N*DW-1:0]  a_mdat, b_mdat;
    logic [N-1:0]     a_ack, a_err, a_rty, a_grant;
    logic [N-1:0]     b_ack, b_err, b_rty, b_grant;
    logic [AW-1:0]    a_adr, b_adr;
    logic [DW-1:0]    a_sdat, b_sdat;
    logic [SW-1:0]    a_sel, b_sel;
    logic             a_we, a_cyc, a_stb, a_tmo;
    logic             b_we, b_cyc, b_stb, b_tmo;
    logic [2:0]       a_cti, b_cti;
    logic [1:0]       a_bte, b_bte;

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(a_mdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
        .wbs_adr_o(a_adr), .wbs_dat_o(a_sdat), .wbs_sel_o(a_sel), .wbs_we_o(a_we),
        .wbs_cyc_o(a_cyc), .wbs_stb_o(a_stb), .wbs_cti_o(a_cti), .wbs_bte_o(a_bte),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(a_grant), .timeout_o(a_tmo)
    );

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(0)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
        .wbs_adr_o(b_adr), .wbs_dat_o(b_sdat), .wbs_sel_o(b_sel), .wbs_we_o(b_we),
        .wbs_cyc_o(b_cyc), .wbs_stb_o(b_stb), .wbs_cti_o(b_cti), .wbs_bte_o(b_bte),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(b_grant), .timeout_o(b_tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), previous owner, stall count, abort flag.
    int m_owner[2];
    int m_last[2];
    int m_stall[2];
    bit m_abort[2];
    int lim[2] = '{8, 0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = N - 1;
            m_stall[k] = 0;
            m_abort[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit t;
        t = s_ack | s_err | s_rty;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_owner[k] = -1; m_last[k] = N - 1; m_stall[k] = 0; m_abort[k] = 1'b0;
            end else if (m_owner[k] < 0) begin
                for (int d = N; d >= 1; d--)
                    if (m_cyc[(m_last[k] + d) % N]) m_owner[k] = (m_last[k] + d) % N;
            end else if (m_abort[k]) begin
                m_abort[k] = 1'b0;
                m_stall[k] = 0;
                if (!m_cyc[m_owner[k]]) begin m_last[k] = m_owner[k]; m_owner[k] = -1; end
            end else if (!m_cyc[m_owner[k]]) begin
                m_last[k] = m_owner[k]; m_owner[k] = -1; m_stall[k] = 0;
            end else if (m_stb[m_owner[k]] && !t) begin
                if (lim[k] > 0 && m_stall[k] == lim[k]) m_abort[k] = 1'b1;
                m_stall[k]++;
            end else begin
                m_stall[k] = 0;
            end
        end
    endtask

    task automatic check_inst(input int k, input string nm,
                              input logic [N-1:0] grant, input logic [N-1:0] ack,
                              input logic [N-1:0] err, input logic [N-1:0] rty,
                              input logic cyc, input logic stb, input logic we,
                              input logic tmo, input logic [AW-1:0] adr,
                              input logic [2:0] cti);
        logic [N-1:0] eg, eack, eerr, erty;
        logic ecyc, estb, etmo;
        int o;
        o = m_owner[k];
        eg = '0; eack = '0; eerr = '0; erty = '0; ecyc = 1'b0; estb = 1'b0; etmo = 1'b0;
        if (o >= 0) eg[o] = 1'b1;
        if (o >= 0 && m_abort[k]) begin
            eerr = eg;
            etmo = 1'b1;
        end else if (o >= 0) begin
            ecyc = m_cyc[o];
            estb = m_stb[o];
            if (s_ack) eack = eg;
            if (s_err) eerr = eg;
            if (s_rty) erty = eg;
        end
        check({nm, "_grant"}, grant, eg);
        check({nm, "_ack"}, ack, eack);
        check({nm, "_err"}, err, eerr);
        check({nm, "_rty"}, rty, erty);
        check({nm, "_cyc"}, cyc, ecyc);
        check({nm, "_stb"}, stb, estb);
        check({nm, "_timeout"}, tmo, etmo);
        if (o >= 0 && !m_abort[k]) begin
            check({nm, "_adr"}, adr, m_adr[o*AW +: AW]);
            check({nm, "_we"}, we, m_we[o]);
            check({nm, "_cti"}, cti, m_cti[o*3 +: 3]);
        end else if (o < 0) begin
            check({nm, "_we_idle"}, we, 1'b0);
        end
    endtask

    task automatic settle();
        #1;
        check_inst(0, "a", a_grant, a_ack, a_err, a_rty, a_cyc, a_stb, a_we, a_tmo, a_adr, a_cti);
        check_inst(1, "b", b_grant, b_ack, b_err, b_rty, b_cyc, b_stb, b_we, b_tmo, b_adr, b_cti);
        for (int i = 0; i < N; i++) check("dat_rep", a_mdat[i*DW +: DW], s_dat);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                         input logic [2:0] cti);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_cti[i*3 +: 3] = cti;
        m_bte[i*2 +: 2] = 2'b01;
        m_adr[i*AW +: AW] = AW'($urandom);
        m_dat[i*DW +: DW] = DW'($urandom);
        m_sel[i*SW +: SW] = '1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 1'b0, 3'b000);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    int hold[N];
    int sstall;
    int r;

    initial begin
        rst_n = 1'b0;
        s_dat = 16'h5a5a;
        idle_all();
        @(posedge clk);
        @(negedge clk);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // Masters 0 and 1 request together; master 0 wins, three acks, then release.
        set_m(0, 1, 1, 0, 3'b000);
        set_m(1, 1, 1, 1, 3'b000);
        settle(); check("d1_grant_T", a_grant, 3'b000); advance();
        s_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            settle();
            check("d1_grant", a_grant, 3'b001);
            check("d1_ack", a_ack, 3'b001);
            advance();
        end
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 3'b000);
        settle(); check("d1_rel_cyc", a_cyc, 1'b0); advance();
        settle(); check("d1_idle", a_grant, 3'b000); advance();

        // Master 1 bursts four beats while master 0 waits.
        set_m(0, 1, 1, 0, 3'b000);
        s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_m(1, 1, 1, 1, (b < 3) ? 3'b010 : 3'b111);
            settle();
            check("d2_grant", a_grant, 3'b010);
            check("d2_ack", a_ack, 3'b010);
            check("d2_cti", a_cti, (b < 3) ? 3'b010 : 3'b111);
            advance();
        end
        s_ack = 1'b0;
        set_m(1, 0, 0, 0, 3'b000);
        tick();
        settle(); check("d2_gap", a_grant, 3'b000); advance();
        settle(); check("d2_regrant", a_grant, 3'b001); advance();
        idle_all();
        tick(); tick();

        // Slave never answers: abort exactly nine cycles after the slave sees stb.
        set_m(0, 1, 1, 0, 3'b000);
        for (int j = 0; j <= 10; j++) begin
            settle();
            check("d3_timeout", a_tmo, (j == 10) ? 1'b1 : 1'b0);
            if (j == 10) begin
                check("d3_err", a_err, 3'b001);
                check("d3_cyc", a_cyc, 1'b0);
            end
            advance();
        end
        idle_all();
        tick(); tick(); tick();

        // Ack lands in the very cycle the count reaches the limit.
        set_m(0, 1, 1, 0, 3'b000);
        for (int j = 0; j <= 10; j++) begin
            s_ack = (j == 9);
            settle();
            if (j == 9) begin
                check("d4_ack", a_ack, 3'b001);
                check("d4_err", a_err, 3'b000);
            end
            check("d4_timeout", a_tmo, 1'b0);
            advance();
        end
        idle_all();
        tick(); tick();

        // Reset in the middle of a burst.
        set_m(0, 1, 1, 0, 3'b000);
        set_m(1, 1, 1, 1, 3'b010);
        s_ack = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("d5_grant", a_grant, 3'b000);
        check("d5_cyc", a_cyc, 1'b0);
        check("d5_stb", a_stb, 1'b0);
        check("d5_we", a_we, 1'b0);
        check("d5_ack", a_ack, 3'b000);
        advance();
        settle(); check("d5_first", a_grant, 3'b001); advance();
        idle_all();
        tick(); tick();

        // Watchdog disabled: 1000 stall cycles then a normal ack.
        set_m(0, 1, 1, 0, 3'b000);
        repeat (1001) tick();
        s_ack = 1'b1;
        settle();
        check("d6_ack", b_ack, 3'b001);
        check("d6_err", b_err, 3'b000);
        advance();
        idle_all();
        tick(); tick();

        // Random traffic against the model.
        for (int i = 0; i < N; i++) hold[i] = 0;
        sstall = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0 && $urandom_range(3, 0) == 0) hold[i] = int'($urandom_range(12, 1));
                if (hold[i] > 0) begin
                    set_m(i, 1, ($urandom % 4) != 0, $urandom % 2 == 1, 3'($urandom));
                    hold[i]--;
                end else begin
                    set_m(i, 0, 0, 0, 3'b000);
                end
            end
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            s_dat = DW'($urandom);
            if (sstall > 0) begin
                sstall--;
            end else begin
                r = int'($urandom % 16);
                if (r == 0) sstall = int'($urandom_range(20, 5));
                s_ack = (r > 0 && r < 8);
                s_err = (r == 8);
                s_rty = (r == 9);
            end
            rst_n = ($urandom % 700) != 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
